// File: rtl/game_controller.sv
// Tic-tac-toe turn sequencer and referee: owns the board, validates moves,
// detects wins/draws one cycle after each accepted move and counts finished games.
module game_controller #(
    parameter int COUNT_W         = 14,
    parameter int MAX_GAMES       = 9999,
    parameter bit ALTERNATE_START = 1'b0
) (
    input  logic               clk_g,
    input  logic               rst_g,
    input  logic               move_valid_g,
    input  logic [3:0]         move_cell_g,
    input  logic               new_game_g,
    output logic [2:0]         gameState_g,
    output logic [17:0]        board_g,
    output logic [COUNT_W-1:0] numGamesPlayed_g,
    output logic [7:0]         win_line_g,
    output logic               move_reject_g
);

    typedef enum logic [2:0] {P1_TURN, P2_TURN, CHECK, DRAW, P1_WIN, P2_WIN} state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_GAMES);
    localparam int LA [8] = '{0, 3, 6, 0, 1, 2, 0, 2};
    localparam int LB [8] = '{1, 4, 7, 3, 4, 5, 4, 4};
    localparam int LC [8] = '{2, 5, 8, 6, 7, 8, 8, 6};

    state_t             state_reg, state_next;
    logic               mover_reg, mover_next;       // 0 = P1, 1 = P2
    logic               start_p2_reg, start_p2_next;
    logic [3:0]         move_cnt_reg, move_cnt_next;
    logic [17:0]        board_reg, board_next;
    logic [7:0]         win_reg, win_next;
    logic [COUNT_W-1:0] games_reg, games_next;
    logic               reject_reg, reject_next;
    logic [2:0]         game_state_reg, game_state_next;

    logic [1:0]  mover_code;
    logic [7:0]  line_hit;
    logic [31:0] board_ext;
    logic        cell_empty;
    logic        move_ok;
    logic        outcome;

    assign mover_code = mover_reg ? 2'b10 : 2'b01;
    assign board_ext  = {14'b0, board_reg};
    // The widened board keeps the occupancy lookup in range for cells 9..15.
    assign cell_empty = (board_ext[{move_cell_g, 1'b0} +: 2] == 2'b00);
    assign move_ok    = (move_cell_g <= 4'd8) && cell_empty;
    assign outcome    = (state_reg == DRAW) || (state_reg == P1_WIN) || (state_reg == P2_WIN);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign line_hit[gi] = (board_reg[2*LA[gi] +: 2] == mover_code) &&
                                  (board_reg[2*LB[gi] +: 2] == mover_code) &&
                                  (board_reg[2*LC[gi] +: 2] == mover_code);
        end
    endgenerate

    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            state_reg      <= P1_TURN;
            mover_reg      <= 1'b0;
            start_p2_reg   <= 1'b0;
            move_cnt_reg   <= '0;
            board_reg      <= '0;
            win_reg        <= '0;
            games_reg      <= '0;
            reject_reg     <= 1'b0;
            game_state_reg <= '0;
        end else begin
            state_reg      <= state_next;
            mover_reg      <= mover_next;
            start_p2_reg   <= start_p2_next;
            move_cnt_reg   <= move_cnt_next;
            board_reg      <= board_next;
            win_reg        <= win_next;
            games_reg      <= games_next;
            reject_reg     <= reject_next;
            game_state_reg <= game_state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mover_next    = mover_reg;
        start_p2_next = start_p2_reg;
        move_cnt_next = move_cnt_reg;
        board_next    = board_reg;
        win_next      = win_reg;
        games_next    = games_reg;
        reject_next   = 1'b0;
        if (new_game_g) begin
            // A simultaneous move is silently dropped.
            start_p2_next = ALTERNATE_START ? ~start_p2_reg : start_p2_reg;
            state_next    = start_p2_next ? P2_TURN : P1_TURN;
            mover_next    = start_p2_next;
            move_cnt_next = '0;
            board_next    = '0;
            win_next      = '0;
            if (outcome && games_reg != MAX_CNT)
                games_next = games_reg + 1'b1;
        end else begin
            case (state_reg)
                P1_TURN, P2_TURN: begin
                    if (move_valid_g) begin
                        if (move_ok) begin
                            for (int k = 0; k < 9; k++)
                                if (move_cell_g == 4'(k))
                                    board_next[2*k +: 2] = (state_reg == P2_TURN) ? 2'b10 : 2'b01;
                            mover_next    = (state_reg == P2_TURN);
                            move_cnt_next = move_cnt_reg + 4'd1;
                            state_next    = CHECK;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    reject_next = move_valid_g;
                    if (|line_hit) begin
                        state_next = mover_reg ? P2_WIN : P1_WIN;
                        win_next   = line_hit;
                    end else if (move_cnt_reg == 4'd9) begin
                        state_next = DRAW;
                    end else begin
                        state_next = mover_reg ? P1_TURN : P2_TURN;
                    end
                end
                default: reject_next = move_valid_g;
            endcase
        end
    end

    // During CHECK the display still shows whose move is being judged.
    always_comb begin
        game_state_next = 3'd0;
        case (state_next)
            P1_TURN: game_state_next = 3'd0;
            P2_TURN: game_state_next = 3'd1;
            CHECK:   game_state_next = {2'b00, mover_next};
            DRAW:    game_state_next = 3'd2;
            P1_WIN:  game_state_next = 3'd3;
            P2_WIN:  game_state_next = 3'd4;
            default: game_state_next = 3'd0;
        endcase
    end

    assign gameState_g      = game_state_reg;
    assign board_g          = board_reg;
    assign numGamesPlayed_g = games_reg;
    assign win_line_g       = win_reg;
    assign move_reject_g    = reject_reg;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed games plus random play, each cycle compared
// against a cell-array model of the game rules.
module tb_game_controller;

    localparam int CW   = 14;
    localparam int MAXG = 3;

    logic          clk_g = 1'b0;
    logic          rst_g = 1'b1;
    logic          move_valid_g = 1'b0;
    logic [3:0]    move_cell_g = '0;
    logic          new_game_g = 1'b0;
    logic [2:0]    gameState_g;
    logic [17:0]   board_g;
    logic [CW-1:0] numGamesPlayed_g;
    logic [7:0]    win_line_g;
    logic          move_reject_g;

    int checks = 0;
    int errors = 0;

    game_controller #(.COUNT_W(CW), .MAX_GAMES(MAXG), .ALTERNATE_START(1'b1)) dut (
        .clk_g(clk_g), .rst_g(rst_g), .move_valid_g(move_valid_g), .move_cell_g(move_cell_g),
        .new_game_g(new_game_g), .gameState_g(gameState_g), .board_g(board_g),
        .numGamesPlayed_g(numGamesPlayed_g), .win_line_g(win_line_g), .move_reject_g(move_reject_g)
    );

    always #5 clk_g = ~clk_g;

    // Reference model: cells hold 0 empty, 1 P1, 2 P2; m_out is 0 while playing.
    int m_cells [9];
    int m_turn, m_out, m_moves, m_count, m_start, m_win, m_rej;
    bit m_pend;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic model_reset();
        foreach (m_cells[k]) m_cells[k] = 0;
        m_turn = 0; m_out = 0; m_moves = 0; m_count = 0; m_start = 0;
        m_win = 0; m_rej = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit ng);
        m_rej = 0;
        if (ng) begin
            if (m_out != 0 && m_count < MAXG) m_count++;
            m_start = 1 - m_start;
            foreach (m_cells[k]) m_cells[k] = 0;
            m_turn = m_start; m_out = 0; m_moves = 0; m_win = 0; m_pend = 0;
        end else if (m_pend) begin
            m_rej = v;
            m_pend = 0;
            m_win = 0;
            for (int l = 0; l < 8; l++)
                if (m_cells[lines[l][0]] == m_turn + 1 && m_cells[lines[l][1]] == m_turn + 1 &&
                    m_cells[lines[l][2]] == m_turn + 1)
                    m_win += (1 << l);
            if (m_win != 0) m_out = 3 + m_turn;
            else if (m_moves == 9) m_out = 2;
            else m_turn = 1 - m_turn;
        end else if (m_out != 0) begin
            m_rej = v;
        end else if (v) begin
            if (c <= 8 && m_cells[c] == 0) begin
                m_cells[c] = m_turn + 1;
                m_moves++;
                m_pend = 1;
            end else begin
                m_rej = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [17:0] eb;
        logic [2:0]  egs;
        eb = '0;
        for (int k = 0; k < 9; k++) eb[2*k +: 2] = 2'(m_cells[k]);
        egs = (m_out != 0) ? 3'(m_out) : 3'(m_turn);
        checks++;
        assert (gameState_g === egs) else begin
            errors++; $error("FAIL %s gameState got %0d exp %0d", tag, gameState_g, egs);
        end
        checks++;
        assert (board_g === eb) else begin
            errors++; $error("FAIL %s board got %h exp %h", tag, board_g, eb);
        end
        checks++;
        assert (numGamesPlayed_g === CW'(m_count)) else begin
            errors++; $error("FAIL %s games got %0d exp %0d", tag, numGamesPlayed_g, m_count);
        end
        checks++;
        assert (win_line_g === 8'(m_win)) else begin
            errors++; $error("FAIL %s win_line got %b exp %b", tag, win_line_g, 8'(m_win));
        end
        checks++;
        assert (move_reject_g === 1'(m_rej)) else begin
            errors++; $error("FAIL %s reject got %b exp %b", tag, move_reject_g, 1'(m_rej));
        end
    endtask

    task automatic step(input string tag, input bit v, input int c, input bit ng);
        @(negedge clk_g);
        move_valid_g = v;
        move_cell_g  = 4'(c);
        new_game_g   = ng;
        @(posedge clk_g);
        #1;
        model_step(v, c, ng);
        check_all(tag);
        move_valid_g = 1'b0;
        new_game_g   = 1'b0;
    endtask

    task automatic play(input string tag, input int seq [$]);
        foreach (seq[i]) begin
            step(tag, 1'b1, seq[i], 1'b0);
            step(tag, 1'b0, 0, 1'b0);
            step(tag, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk_g);
        #3 rst_g = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk_g);
        rst_g = 1'b0;
        step(tag, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int v, c, ng;
        model_reset();
        #12;
        check_all("reset_hold");
        @(negedge clk_g);
        rst_g = 1'b0;
        step("reset_release", 1'b0, 0, 1'b0);

        play("p1_row_win", '{0, 3, 1, 4, 2});
        step("post_win_move", 1'b1, 5, 1'b0);
        step("post_win_idle", 1'b0, 0, 1'b0);
        step("new_game1", 1'b0, 0, 1'b1);

        play("draw", '{0, 1, 2, 4, 3, 5, 7, 6, 8});
        step("new_game2", 1'b0, 0, 1'b1);

        step("rej_cell9", 1'b1, 9, 1'b0);
        step("p1_cell4", 1'b1, 4, 1'b0);
        step("rej_in_check", 1'b1, 0, 1'b0);
        step("rej_occupied", 1'b1, 4, 1'b0);
        step("idle", 1'b0, 0, 1'b0);
        step("p2_cell0", 1'b1, 0, 1'b0);
        step("idle", 1'b0, 0, 1'b0);
        step("ng_with_move", 1'b1, 8, 1'b1);
        step("idle", 1'b0, 0, 1'b0);

        for (int g = 0; g < 4; g++) begin
            play("sat_game", '{0, 3, 1, 4, 2});
            step("sat_new", 1'b0, 0, 1'b1);
        end

        for (int i = 0; i < 600; i++) begin
            ng = (m_out != 0) ? int'($urandom_range(3) == 0) : int'($urandom_range(39) == 0);
            v  = int'($urandom_range(2) != 0);
            c  = int'($urandom_range(10));
            step("random", 1'(v), c, 1'(ng));
        end

        play("mid_game", '{4, 0});
        async_reset("async_reset");
        play("after_reset", '{8, 6, 4, 2, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout bench did not finish got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
